writeback_queue: RTL and testbench

Write-back buffer that drives the write port of the processor's 32 x 32-bit register bank (write enable, 6-bit destination, 32-bit data). It accepts results from two producers, the ALU path and the memory-load path, and queues them in a 4-entry in-order FIFO. It drains one entry per cycle onto the bank write port. A per-register busy mask lets decode stall on pending destinations.

---
 rtl/writeback_queue.sv | 130 +++++++++++++
 tb/tb_writeback_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Write-back buffer for the 32 x 32-bit register bank: merges ALU and load results
// into a 4-entry in-order queue and drains one entry per cycle onto the bank write port.
module writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_addr,
   input  logic [31:0]   alu_data,
   output logic          alu_ready,
   input  logic          mem_valid,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_data,
   output logic          mem_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic [31:0]   busy_mask,
   output logic [2:0]    count,
   output logic          empty,
   output logic          full
);

   // Register 0 is hardwired and addr[5] selects outside the bank; such entries never write.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a[5] == 1'b0) && (a[4:0] != 5'd0);
   endfunction

   // Slot idx holds a live entry when its distance from the read pointer is below count.
   function automatic logic slot_live(input logic [1:0] idx, input logic [1:0] rd,
                                      input logic [2:0] cnt);
      logic [1:0] ofs;
      ofs = idx - rd;
      return ({1'b0, ofs} < cnt);
   endfunction

   logic [AW-1:0] addr_q_r [DEPTH];
   logic [31:0]   data_q_r [DEPTH];
   logic [1:0]    rd_ptr_r;
   logic [1:0]    wr_ptr_r;
   logic [2:0]    count_r;
   logic          wr_en_r;
   logic [AW-1:0] wr_addr_r;
   logic [31:0]   wr_data_r;

   logic          alu_push_s;
   logic          mem_push_s;
   logic          pop_s;
   logic [1:0]    mem_slot_s;
   logic [2:0]    count_next_s;
   logic [31:0]   busy_s;

   assign alu_ready    = (count_r < 3'd4);
   assign mem_ready    = (count_r < 3'd3) | ((count_r == 3'd3) & ~alu_valid);
   assign alu_push_s   = alu_valid & alu_ready & ~flush;
   assign mem_push_s   = mem_valid & mem_ready & ~flush;
   assign pop_s        = (count_r != 3'd0) & ~flush;
   // The ALU entry takes the first free slot so it drains ahead of a same-cycle load.
   assign mem_slot_s   = wr_ptr_r + {1'b0, alu_push_s};
   assign count_next_s = count_r + {2'b00, alu_push_s} + {2'b00, mem_push_s} - {2'b00, pop_s};

   // Queue pointers, occupancy and the registered bank write port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_r  <= 2'd0;
         wr_ptr_r  <= 2'd0;
         count_r   <= 3'd0;
         wr_en_r   <= 1'b0;
         wr_addr_r <= {AW{1'b0}};
         wr_data_r <= 32'd0;
      end else if (flush) begin
         rd_ptr_r  <= 2'd0;
         wr_ptr_r  <= 2'd0;
         count_r   <= 3'd0;
         wr_en_r   <= 1'b0;
      end else begin
         count_r  <= count_next_s;
         wr_ptr_r <= wr_ptr_r + {1'b0, alu_push_s} + {1'b0, mem_push_s};
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + 2'd1;
            wr_en_r   <= addr_ok(addr_q_r[rd_ptr_r]);
            wr_addr_r <= addr_q_r[rd_ptr_r];
            wr_data_r <= data_q_r[rd_ptr_r];
         end else begin
            wr_en_r   <= 1'b0;
         end
      end
   end

   // Entry storage; written only by accepted pushes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q_r[i] <= {AW{1'b0}};
            data_q_r[i] <= 32'd0;
         end
      end else begin
         if (alu_push_s) begin
            addr_q_r[wr_ptr_r] <= alu_addr;
            data_q_r[wr_ptr_r] <= alu_data;
         end
         if (mem_push_s) begin
            addr_q_r[mem_slot_s] <= mem_addr;
            data_q_r[mem_slot_s] <= mem_data;
         end
      end
   end

   // Pending-destination mask over live queue slots plus the output stage.
   always_comb begin
      busy_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_s = busy_s | ((slot_live(2'(i), rd_ptr_r, count_r) && addr_ok(addr_q_r[i]))
                            ? (32'd1 << addr_q_r[i][4:0]) : 32'd0);
      end
      busy_s = busy_s | ((wr_en_r && addr_ok(wr_addr_r)) ? (32'd1 << wr_addr_r[4:0]) : 32'd0);
   end

   assign busy_mask = {busy_s[31:1], 1'b0};
   assign wr_en     = wr_en_r;
   assign wr_addr   = wr_addr_r;
   assign wr_data   = wr_data_r;
   assign count     = count_r;
   assign empty     = (count_r == 3'd0);
   assign full      = (count_r == 3'd4);

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: expected bank writes are queued as pushes are
// accepted and compared as the output stage presents them.
module tb_writeback_queue;

   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic        alu_valid, mem_valid;
   logic [5:0]  alu_addr, mem_addr;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready, wr_en, empty, full;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data, busy_mask;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t        sb_q[$];
   logic        m_en;
   logic [5:0]  m_addr;
   logic [31:0] m_data;

   always #5 clk = ~clk;

   writeback_queue #(.DEPTH(4), .AW(6)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_mask(busy_mask),
      .count(count), .empty(empty), .full(full)
   );

   function automatic logic addr_valid(input logic [5:0] a);
      return (a >= 6'd1) && (a <= 6'd31);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = 32'd0;
      foreach (sb_q[i]) if (addr_valid(sb_q[i].addr)) b[sb_q[i].addr[4:0]] = 1'b1;
      if (m_en) b[m_addr[4:0]] = 1'b1;
      return b;
   endfunction

   task automatic drive(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [5:0] ma, input logic [31:0] md);
      alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
   endtask

   // One clock: check pre-edge status against the model, advance the model, check the write port.
   task automatic cycle();
      int   cnt;
      logic exp_ar, exp_mr;
      ent_t head;
      #1;
      cnt    = sb_q.size();
      exp_ar = (cnt < 4);
      exp_mr = (cnt < 3) || ((cnt == 3) && !alu_valid);
      n_checks++; if (alu_ready !== exp_ar) begin n_fail++; $display("FAIL alu_ready: got %b want %b", alu_ready, exp_ar); end
      n_checks++; if (mem_ready !== exp_mr) begin n_fail++; $display("FAIL mem_ready: got %b want %b", mem_ready, exp_mr); end
      n_checks++; if (count !== 3'(cnt)) begin n_fail++; $display("FAIL count: got %0d want %0d", count, cnt); end
      n_checks++; if (empty !== (cnt == 0)) begin n_fail++; $display("FAIL empty: got %b want %b", empty, cnt == 0); end
      n_checks++; if (full !== (cnt == 4)) begin n_fail++; $display("FAIL full: got %b want %b", full, cnt == 4); end
      n_checks++; if (busy_mask !== model_busy()) begin n_fail++; $display("FAIL busy_mask: got %h want %h", busy_mask, model_busy()); end
      if (!rst_n) begin
         sb_q.delete(); m_en = 1'b0; m_addr = 6'd0; m_data = 32'd0;
      end else if (flush) begin
         sb_q.delete(); m_en = 1'b0;
      end else begin
         if (cnt > 0) begin
            head = sb_q.pop_front();
            m_en = addr_valid(head.addr); m_addr = head.addr; m_data = head.data;
         end else begin
            m_en = 1'b0;
         end
         if (alu_valid && exp_ar) sb_q.push_back('{addr: alu_addr, data: alu_data});
         if (mem_valid && exp_mr) sb_q.push_back('{addr: mem_addr, data: mem_data});
      end
      @(posedge clk); #1;
      n_checks++; if (wr_en !== m_en) begin n_fail++; $display("FAIL wr_en: got %b want %b", wr_en, m_en); end
      n_checks++; if (wr_addr !== m_addr) begin n_fail++; $display("FAIL wr_addr: got %0d want %0d", wr_addr, m_addr); end
      n_checks++; if (wr_data !== m_data) begin n_fail++; $display("FAIL wr_data: got %h want %h", wr_data, m_data); end
   endtask

   task automatic idle(input int n);
      drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b1;
      drive(1'b1, 6'd9, 32'hDEAD_BEEF, 1'b1, 6'd10, 32'h1234_5678);
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({wr_en, wr_addr, wr_data} !== 39'd0) begin n_fail++; $display("FAIL reset_wr: got %b/%0d/%h want 0", wr_en, wr_addr, wr_data); end
      n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
      n_checks++; if ({count, empty, full} !== 5'b000_1_0) begin n_fail++; $display("FAIL reset_status: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
      sb_q.delete(); m_en = 1'b0; m_addr = 6'd0; m_data = 32'd0;
      rst_n = 1'b1; flush = 1'b0;
      idle(1);
   endtask

   task automatic test_single_push();
      drive(1'b1, 6'd5, 32'h0000_00AA, 1'b0, 6'd0, 32'd0);
      cycle();
      drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      n_checks++; if (count !== 3'd1 || busy_mask !== 32'h20) begin n_fail++; $display("FAIL single_queued: got count=%0d busy=%h want 1/00000020", count, busy_mask); end
      cycle();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd5 || wr_data !== 32'hAA) begin n_fail++; $display("FAIL single_write: got %b/%0d/%h want 1/5/aa", wr_en, wr_addr, wr_data); end
      n_checks++; if (busy_mask !== 32'h20) begin n_fail++; $display("FAIL single_busy_out: got %h want 00000020", busy_mask); end
      cycle();
      n_checks++; if (busy_mask !== 32'd0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL single_clear: got busy=%h wr_en=%b want 0/0", busy_mask, wr_en); end
   endtask

   task automatic test_dual_push();
      drive(1'b1, 6'd3, 32'h11, 1'b1, 6'd3, 32'h22);
      #1;
      n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin n_fail++; $display("FAIL dual_ready: got %b%b want 11", alu_ready, mem_ready); end
      cycle();
      drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      cycle();
      n_checks++; if (wr_en !== 1'b1 || wr_data !== 32'h11) begin n_fail++; $display("FAIL dual_first: got %b/%h want 1/11", wr_en, wr_data); end
      cycle();
      n_checks++; if (wr_en !== 1'b1 || wr_data !== 32'h22) begin n_fail++; $display("FAIL dual_second: got %b/%h want 1/22", wr_en, wr_data); end
      idle(2);
   endtask

   task automatic test_fill_priority();
      drive(1'b1, 6'd10, 32'hA0, 1'b1, 6'd11, 32'hB0);
      cycle();
      drive(1'b1, 6'd12, 32'hA1, 1'b1, 6'd13, 32'hB1);
      cycle();
      drive(1'b1, 6'd14, 32'hA2, 1'b1, 6'd15, 32'hB2);
      #1;
      n_checks++; if (count !== 3'd3 || alu_ready !== 1'b1 || mem_ready !== 1'b0) begin n_fail++; $display("FAIL fill_prio: got count=%0d ready=%b%b want 3/10", count, alu_ready, mem_ready); end
      cycle();
      // With a pop on every non-empty edge, one ALU push at count 3 keeps it at 3.
      n_checks++; if (count !== 3'd3 || full !== 1'b0) begin n_fail++; $display("FAIL fill_hold: got count=%0d full=%b want 3/0", count, full); end
      idle(5);
   endtask

   task automatic test_dropped();
      drive(1'b1, 6'd0, 32'h55, 1'b0, 6'd0, 32'd0);
      cycle();
      drive(1'b1, 6'h21, 32'h66, 1'b0, 6'd0, 32'd0);
      cycle();
      n_checks++; if (wr_en !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL drop_first: got wr_en=%b busy=%h want 0/0", wr_en, busy_mask); end
      drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      cycle();
      n_checks++; if (wr_en !== 1'b0 || wr_addr !== 6'h21 || busy_mask !== 32'd0 || count !== 3'd0) begin n_fail++; $display("FAIL drop_second: got %b/%h/%h/%0d want 0/21/0/0", wr_en, wr_addr, busy_mask, count); end
      idle(1);
   endtask

   task automatic test_flush();
      drive(1'b1, 6'd1, 32'h101, 1'b1, 6'd2, 32'h202);
      cycle();
      drive(1'b1, 6'd4, 32'h404, 1'b0, 6'd0, 32'd0);
      cycle();
      drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      flush = 1'b1;
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'h101 || busy_mask !== 32'h16) begin n_fail++; $display("FAIL flush_pre: got %b/%0d/%h busy=%h want 1/1/101 16", wr_en, wr_addr, wr_data, busy_mask); end
      cycle();
      flush = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0 || wr_en !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL flush_post: got count=%0d wr_en=%b busy=%h want 0/0/0", count, wr_en, busy_mask); end
      idle(1);
   endtask

   task automatic test_reset_priority();
      drive(1'b1, 6'd7, 32'h77, 1'b1, 6'd8, 32'h88);
      cycle();
      drive(1'b1, 6'd9, 32'h99, 1'b0, 6'd0, 32'd0);
      rst_n = 1'b0; flush = 1'b1;
      cycle();
      n_checks++; if ({count, empty, full, wr_en, wr_addr, wr_data, busy_mask} !== {3'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL rst_prio: got count=%0d en=%b addr=%0d data=%h busy=%h", count, wr_en, wr_addr, wr_data, busy_mask); end
      rst_n = 1'b1; flush = 1'b0;
      idle(1);
      n_checks++; if (count !== 3'd0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_nopush: got count=%0d wr_en=%b want 0/0", count, wr_en); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 40)), $urandom,
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 40)), $urandom);
         flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      flush = 1'b0;
      idle(6);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      test_reset();
      test_single_push();
      test_dual_push();
      test_fill_priority();
      test_dropped();
      test_flush();
      test_reset_priority();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
